// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide scheduler for the P7 pipeline.
// Computes the HI/LO result at issue time, holds it in private pending
// registers, and publishes it after a fixed busy period counted down by cnt.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_mlu_use,
  input  logic [2:0]  E_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        E_flush,
  output logic        D_stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [31:0]    p_hi;
  logic [31:0]    p_lo;

  logic           is_mul;
  logic           is_div;
  logic           accept;
  logic [31:0]    res_hi;
  logic [31:0]    res_lo;
  logic signed [63:0] s_rs64;
  logic signed [63:0] s_rt64;
  logic signed [63:0] s_prod;
  logic [63:0]    u_prod;
  logic [31:0]    safe_rt;
  logic signed [31:0] s_quot;
  logic signed [31:0] s_rem;
  logic [31:0]    u_quot;
  logic [31:0]    u_rem;

  assign is_mul  = (E_op == OP_MULT) || (E_op == OP_MULTU);
  assign is_div  = (E_op == OP_DIV)  || (E_op == OP_DIVU);
  assign accept  = (is_mul || is_div) && !busy && !E_flush;

  // Decode must hold while the MDU is occupied or an MDU op is about to start
  assign D_stall = D_mlu_use && (busy || is_mul || is_div);

  // Result datapath for the op currently in Execute, including the
  // divide-by-zero and signed-overflow corner cases
  always_comb begin
    s_rs64  = {{32{E_rs[31]}}, E_rs};
    s_rt64  = {{32{E_rt[31]}}, E_rt};
    s_prod  = s_rs64 * s_rt64;
    u_prod  = {32'd0, E_rs} * {32'd0, E_rt};
    safe_rt = (E_rt == 32'd0) ? 32'd1 : E_rt;
    s_quot  = $signed(E_rs) / $signed(safe_rt);
    s_rem   = $signed(E_rs) % $signed(safe_rt);
    u_quot  = E_rs / safe_rt;
    u_rem   = E_rs % safe_rt;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    case (E_op)
      OP_MULT: begin
        res_hi = s_prod[63:32];
        res_lo = s_prod[31:0];
      end
      OP_MULTU: begin
        res_hi = u_prod[63:32];
        res_lo = u_prod[31:0];
      end
      OP_DIV: begin
        if (E_rt == 32'd0) begin
          res_hi = E_rs;
          res_lo = 32'hFFFF_FFFF;
        end else if (E_rs == 32'h8000_0000 && E_rt == 32'hFFFF_FFFF) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = s_rem;
          res_lo = s_quot;
        end
      end
      OP_DIVU: begin
        if (E_rt == 32'd0) begin
          res_hi = E_rs;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = u_rem;
          res_lo = u_quot;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Scheduler FSM: accept/latch in IDLE, count down and publish in RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            p_hi  <= res_hi;
            p_lo  <= res_lo;
            cnt   <= is_mul ? MULT_CNT : DIV_CNT;
            busy  <= 1'b1;
            state <= RUN;
          end else if (!E_flush && E_op == OP_MTHI) begin
            hi <= E_rs;
          end else if (!E_flush && E_op == OP_MTLO) begin
            lo <= E_rs;
          end
        end
        RUN: begin
          if (cnt == LAST_CNT) begin
            hi    <= p_hi;
            lo    <= p_lo;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - LAST_CNT;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: scoreboard bench for the multiply/divide scheduler.
module tb_mdu_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        D_mlu_use;
  logic [2:0]  E_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        E_flush;
  logic        D_stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk),
    .reset(reset),
    .D_mlu_use(D_mlu_use),
    .E_op(E_op),
    .E_rs(E_rs),
    .E_rt(E_rt),
    .E_flush(E_flush),
    .D_stall(D_stall),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Step one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an MDU op for one cycle and push its expected result
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo, input int ncyc);
    exp_t e;
    E_op = op;
    E_rs = rs;
    E_rt = rt;
    e.hi = ehi;
    e.lo = elo;
    e.cycles = 8'(ncyc);
    sb.push_back(e);
    step();
    E_op = 3'd0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept_busy op=%0d got=%b want=1", op, busy);
    end
  endtask

  // Count busy cycles until completion, then pop and compare the result
  task automatic drain(input int pre, input string name);
    exp_t e;
    int cycles;
    cycles = pre;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      step();
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s_sb got=empty want=entry", name);
      return;
    end
    e = sb.pop_front();
    if (cycles !== int'(e.cycles)) begin
      bad++;
      $display("[TB] FAIL %s_cycles got=%0d want=%0d", name, cycles, e.cycles);
    end
    total++;
    if (hi !== e.hi) begin
      bad++;
      $display("[TB] FAIL %s_hi got=%h want=%h", name, hi, e.hi);
    end
    total++;
    if (lo !== e.lo) begin
      bad++;
      $display("[TB] FAIL %s_lo got=%h want=%h", name, lo, e.lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    D_mlu_use = 1'b0;
    E_op = 3'd0;
    E_rs = 32'd0;
    E_rt = 32'd0;
    E_flush = 1'b0;
    repeat (2) step();
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || D_stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got=busy%b hi%h lo%h st%b want=0/0/0/0", busy, hi, lo, D_stall);
    end
    D_mlu_use = 1'b1;
    E_op = 3'd1;
    #1;
    total++;
    if (D_stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_stall_comb got=%b want=1", D_stall);
    end
    E_op = 3'd0;
    D_mlu_use = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    D_mlu_use = 1'b1;
    E_op = 3'd1;
    #1;
    total++;
    if (D_stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mult_accept_stall got=%b want=1", D_stall);
    end
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_N);
    total++;
    if (D_stall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mult_busy_stall got=%b want=1", D_stall);
    end
    drain(0, "mult");
    total++;
    if (D_stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mult_idle_stall got=%b want=0", D_stall);
    end
    D_mlu_use = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, DIV_N);
    drain(0, "divu");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N);
    drain(0, "div_b2b");
  endtask

  task automatic test_div_special();
    issue(3'd3, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, DIV_N);
    drain(0, "div_zero");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_N);
    drain(0, "div_ovf");
    issue(3'd4, 32'h8000_0000, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
    drain(0, "divu_zero");
  endtask

  task automatic test_random_mult();
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    longint sp;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      if (i[0]) begin
        p = {32'd0, a} * {32'd0, b};
        issue(3'd2, a, b, p[63:32], p[31:0], MULT_N);
        drain(0, "multu_rand");
      end else begin
        sp = longint'(signed'(a)) * longint'(signed'(b));
        p = sp;
        issue(3'd1, a, b, p[63:32], p[31:0], MULT_N);
        drain(0, "mult_rand");
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    D_mlu_use = 1'b1;
    E_op = 3'd5;
    E_rs = 32'hDEAD_BEEF;
    #1;
    total++;
    if (D_stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mthi_stall got=%b want=0", D_stall);
    end
    step();
    total++;
    if (hi !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL mthi_hi got=%h want=deadbeef", hi);
    end
    E_op = 3'd6;
    E_rs = 32'd1;
    step();
    total++;
    if (lo !== 32'd1 || hi !== 32'hDEAD_BEEF) begin
      bad++;
      $display("[TB] FAIL mtlo_lo got=hi%h lo%h want=deadbeef/00000001", hi, lo);
    end
    E_op = 3'd0;
    #1;
    total++;
    if (D_stall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_use_stall got=%b want=0", D_stall);
    end
    D_mlu_use = 1'b0;
  endtask

  task automatic test_flush();
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi = hi;
    old_lo = lo;
    E_op = 3'd1;
    E_rs = 32'd7;
    E_rt = 32'd9;
    E_flush = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || hi !== old_hi || lo !== old_lo) begin
      bad++;
      $display("[TB] FAIL flush_mult got=busy%b hi%h lo%h want=0/%h/%h", busy, hi, lo, old_hi, old_lo);
    end
    E_op = 3'd6;
    E_rs = 32'h5555_AAAA;
    step();
    total++;
    if (lo !== old_lo) begin
      bad++;
      $display("[TB] FAIL flush_mtlo got=%h want=%h", lo, old_lo);
    end
    E_flush = 1'b0;
    E_op = 3'd0;
    issue(3'd1, 32'd1000, 32'd1000, 32'd0, 32'd1000000, MULT_N);
    E_flush = 1'b1;
    E_op = 3'd3;
    E_rs = 32'd50;
    E_rt = 32'd5;
    step();
    E_flush = 1'b0;
    E_op = 3'd0;
    drain(1, "flush_run");
  endtask

  task automatic test_reset_abort();
    issue(3'd3, 32'd77, 32'd7, 32'd0, 32'd11, DIV_N);
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_async got=busy%b hi%h lo%h want=0/0/0", busy, hi, lo);
    end
    sb.delete();
    step();
    reset = 1'b1;
    repeat (DIV_N + 3) step();
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("[TB] FAIL abort_late_write got=busy%b hi%h lo%h want=0/0/0", busy, hi, lo);
    end
  endtask

  // Run every scenario in sequence and report
  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_special();
    test_random_mult();
    test_mthi_mtlo();
    test_flush();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
